call_scheduler: RTL
===================

CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 SHALL have parameter FLOORS, default 7, number of served floors; floor codes are 1..FLOORS and code 0 means "no call".
REQ-002 SHALL have parameter FW, default 3, floor-code width in bits.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named CLK and RST.
REQ-004 SHALL provide ports, in this order:
  CLK  in  1  clock
  RST  in  1  synchronous active-high reset
  interior_call  in  FW  cab button floor code, 0 = none, sampled every cycle
  exterior_call  in  FW  hall button floor code, 0 = none, sampled every cycle
  authorized  in  1  keypad login valid; gates interior_call
  current_floor  in  FW  floor reported by elevator, 0 = invalid
  arrived  in  1  one-cycle pulse: elevator stopped at current_floor with doors opening
  target_floor  out  FW  floor the elevator is to serve next, 0 = none
  target_valid  out  1  target_floor is meaningful
  direction  out  2  00 idle, 01 up, 10 down (11 unused)
  pending  out  FLOORS  bitmap of latched calls, bit i-1 = floor i

Function
REQ-005 SHALL, on each CLK edge with RST=0, set pending bit for nonzero exterior_call regardless of authorized.
REQ-006 SHALL set pending bit for nonzero interior_call only when authorized=1 in the same cycle; otherwise ignore the call silently.
REQ-007 SHALL ignore call codes greater than FLOORS.
REQ-008 SHALL, when arrived=1 and current_floor is nonzero, clear the pending bit of current_floor on that edge; a same-cycle call to that floor is dropped, so clear wins.
REQ-009 SHALL implement FSM states IDLE, UP, DOWN; state drives direction (IDLE=00, UP=01, DOWN=10).
REQ-010 IDLE: if any pending floor is above current_floor, go to UP; else if any is below, go to DOWN; else stay.
REQ-011 UP: if any pending floor is at or above current_floor, stay; else if any is below, go to DOWN; else go to IDLE.
REQ-012 DOWN: mirror of UP (at or below, then above, then IDLE).
REQ-013 SHALL select target_floor as the nearest pending floor in the direction of the next state, including current_floor itself; in IDLE it is current_floor if its bit is set, else 0.
REQ-014 SHALL register target_floor, target_valid and direction; they reflect the pending/state values of the previous edge, so a call sampled at edge k appears on the outputs after edge k+1.
REQ-015 SHALL drive target_valid=1 iff target_floor is nonzero.
REQ-016 SHALL, while current_floor=0, freeze state and outputs while still latching calls into pending.
REQ-017 SHALL handle simultaneous interior and exterior calls to different floors by setting both bits on the same edge.
REQ-018 SHALL treat a repeated call to an already-pending floor as a no-op.

Reset
REQ-019 On RST=1 at a CLK edge, SHALL set pending=0, state=IDLE, target_floor=0, target_valid=0 and direction=00; calls in that cycle are discarded.
REQ-020 Reset mid-travel SHALL drop all pending calls with no memory of the previous direction.

Structure
REQ-021 SHALL place the following in a shared package, also used by the elevator controller:
  - direction encodings
  - FSM state encodings
  - FW
  - FLOOR_NONE=0
REQ-022 SHALL isolate nearest-pending search (above/below current_floor, with priority to distance) in sub-module call_seeker; it is combinational and instantiated once per direction.
REQ-023 SHALL contain no latches; all outputs registered.

Verification
REQ-024 After reset with current_floor=1, exterior_call=5 for one cycle -> pending=0010000 after edge k; after edge k+1, direction=01, target_floor=5, target_valid=1.
REQ-025 With authorized=0, interior_call=3 -> pending unchanged (0); with authorized=1, interior_call=3 -> pending bit 2 set.
REQ-026 current_floor=4 moving UP, pending floors 2 and 6 -> target=6, direction=01; after arrived at 6 -> bit cleared, direction=10, target=2; after arrived at 2 -> direction=00, target_valid=0.
REQ-027 arrived=1 at floor 3 in the same cycle as exterior_call=3 -> bit 2 stays clear.
REQ-028 RST asserted while pending=1010100 and direction=10 -> next edge: pending=0, direction=00, target_floor=0, target_valid=0.
REQ-029 current_floor=0 with exterior_call=2 -> pending bit 1 set; outputs hold until current_floor becomes nonzero.

Source files
------------

// File: rtl/call_scheduler_pkg.sv
// Shared definitions for the call scheduler and the elevator controller.
//   FW          : default floor-code width in bits
//   FLOOR_NONE  : floor code meaning "no call / no target"
//   DIR_*       : encodings carried on the direction bus
//   ST_*        : scheduler FSM state encodings
//   state_to_dir: maps an FSM state onto the direction bus
package call_scheduler_pkg;

  localparam int FW         = 3;
  localparam int FLOOR_NONE = 0;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_UP   = 2'b01;
  localparam logic [1:0] ST_DOWN = 2'b10;

  function automatic logic [1:0] state_to_dir(input logic [1:0] st);
    case (st)
      ST_UP:   state_to_dir = DIR_UP;
      ST_DOWN: state_to_dir = DIR_DOWN;
      default: state_to_dir = DIR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/call_seeker.sv
// Combinational search for the nearest pending floor on one side of the
// current floor, the current floor itself included.
//   SEEK_UP=1 : nearest pending floor >= current_floor
//   SEEK_UP=0 : nearest pending floor <= current_floor
// Ports:
//   pending       in  FLOORS  latched calls, bit i-1 = floor i
//   current_floor in  FW      floor the cab is at
//   nearest       out FW      nearest matching floor, FLOOR_NONE if none
module call_seeker
  import call_scheduler_pkg::*;
#(
  parameter int FLOORS  = 7,
  parameter int FW      = 3,
  parameter bit SEEK_UP = 1'b1
) (
  input  logic [FLOORS-1:0] pending,
  input  logic [FW-1:0]     current_floor,
  output logic [FW-1:0]     nearest
);

  // Scan from the far end toward the cab so the last hit is the closest.
  always_comb begin
    nearest = FW'(FLOOR_NONE);
    if (SEEK_UP) begin
      for (int i = FLOORS; i >= 1; i--) begin
        if (pending[i-1] && (i >= int'(current_floor))) nearest = FW'(i);
      end
    end else begin
      for (int i = 1; i <= FLOORS; i++) begin
        if (pending[i-1] && (i <= int'(current_floor))) nearest = FW'(i);
      end
    end
  end

endmodule

// File: rtl/call_scheduler.sv
// Latches hall and cab calls and decides where the elevator goes next.
// Handshake: there is none; calls are level codes sampled on every edge and
// arrived is a single-cycle pulse qualified by a nonzero current_floor.
// Ports:
//   CLK, RST       clock and synchronous active-high reset
//   interior_call  cab call code (needs authorized), 0 = none
//   exterior_call  hall call code, 0 = none
//   authorized     keypad login valid
//   current_floor  floor reported by the elevator, 0 = invalid
//   arrived        stopped at current_floor, clear its call
//   target_floor   next floor to serve, 0 = none (registered)
//   target_valid   target_floor is nonzero (registered)
//   direction      FSM state as 00 idle / 01 up / 10 down (registered)
//   pending        latched call bitmap, bit i-1 = floor i
module call_scheduler #(
  parameter int FLOORS = 7,
  parameter int FW     = call_scheduler_pkg::FW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FW-1:0]     interior_call,
  input  logic [FW-1:0]     exterior_call,
  input  logic              authorized,
  input  logic [FW-1:0]     current_floor,
  input  logic              arrived,
  output logic [FW-1:0]     target_floor,
  output logic              target_valid,
  output logic [1:0]        direction,
  output logic [FLOORS-1:0] pending
);

  import call_scheduler_pkg::*;

  logic [1:0]        state, state_next;
  logic [FW-1:0]     target_next;
  logic [FLOORS-1:0] pending_next;
  logic [FW-1:0]     up_near, dn_near;
  logic              cur_ok, any_above, any_below, cur_set;

  // Codes of 0 or above FLOORS decode to an empty mask.
  function automatic logic [FLOORS-1:0] floor_mask(input logic [FW-1:0] code);
    floor_mask = '0;
    for (int i = 1; i <= FLOORS; i++) begin
      if (int'(code) == i) floor_mask[i-1] = 1'b1;
    end
  endfunction

  call_seeker #(.FLOORS(FLOORS), .FW(FW), .SEEK_UP(1'b1)) u_seek_up (
    .pending       (pending),
    .current_floor (current_floor),
    .nearest       (up_near)
  );

  call_seeker #(.FLOORS(FLOORS), .FW(FW), .SEEK_UP(1'b0)) u_seek_dn (
    .pending       (pending),
    .current_floor (current_floor),
    .nearest       (dn_near)
  );

  assign cur_ok    = (current_floor != FW'(FLOOR_NONE)) && (int'(current_floor) <= FLOORS);
  // Seekers include the current floor, so "strictly" above/below excludes it.
  assign any_above = (up_near != FW'(FLOOR_NONE)) && (up_near != current_floor);
  assign any_below = (dn_near != FW'(FLOOR_NONE)) && (dn_near != current_floor);
  assign cur_set   = cur_ok && (up_near == current_floor);

  // Arrival clear is applied last so it beats a same-cycle call.
  always_comb begin
    pending_next = pending | floor_mask(exterior_call);
    if (authorized) pending_next = pending_next | floor_mask(interior_call);
    if (arrived) pending_next = pending_next & ~floor_mask(current_floor);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_UP: begin
        if (up_near != FW'(FLOOR_NONE))      state_next = ST_UP;
        else if (dn_near != FW'(FLOOR_NONE)) state_next = ST_DOWN;
        else                                 state_next = ST_IDLE;
      end
      ST_DOWN: begin
        if (dn_near != FW'(FLOOR_NONE))      state_next = ST_DOWN;
        else if (up_near != FW'(FLOOR_NONE)) state_next = ST_UP;
        else                                 state_next = ST_IDLE;
      end
      default: begin
        if (any_above)      state_next = ST_UP;
        else if (any_below) state_next = ST_DOWN;
        else                state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    case (state_next)
      ST_UP:   target_next = up_near;
      ST_DOWN: target_next = dn_near;
      default: target_next = cur_set ? current_floor : FW'(FLOOR_NONE);
    endcase
  end

  // Calls keep latching while the floor is unknown; decisions freeze.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending      <= '0;
      state        <= ST_IDLE;
      target_floor <= FW'(FLOOR_NONE);
      target_valid <= 1'b0;
    end else begin
      pending <= pending_next;
      if (cur_ok) begin
        state        <= state_next;
        target_floor <= target_next;
        target_valid <= (target_next != FW'(FLOOR_NONE));
      end
    end
  end

  assign direction = state_to_dir(state);

endmodule
